water_level_sensor_cond: RTL and testbench
==========================================

Name: water_level_sensor_cond

Overview:
Upstream conditioning stage for the reservoir flow controller. Takes the three raw float-sensor inputs, which are asynchronous and bouncy. It synchronises and debounces them, and checks that the result is a legal thermometer code. It then drives the clean s[3:1] bus consumed by the flow controller, plus a sticky fault flag for sensor disagreement.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised bit must differ from its stable value before the stable value flips (legal range 1..2**CNT_W-1).
CNT_W, 3, width of each per-bit debounce counter.
FAULT_CYCLES, 8, consecutive cycles of an illegal stable vector before fault is raised (legal range 1..255).

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (0 = in reset).
s_raw  input  3 [3:1]  raw sensor levels; bit 1 = lowest sensor; asynchronous to clk.
s  output  3 [3:1]  conditioned sensor vector to the flow controller; always a legal thermometer code.
s_valid  output  1  1 when s reflects a current legal stable vector and no fault is present.
level_changed  output  1  one-cycle pulse, asserted in the same cycle s takes a new value.
fault  output  1  sticky sensor-inconsistency flag.

Behaviour:
- Reset (reset=0, asynchronous): s=000, s_valid=0, level_changed=0, fault=0. Synchroniser flops, stable vector and all counters are cleared to 0. Reset asserted mid-operation aborts everything immediately; no state survives.
- Synchroniser: two flops per bit, s_raw -> q1 -> q2. No logic between the flops.
- Per-bit debounce, evaluated each edge, independently for each of bits 1..3:
  - q2 == stable: cnt <= 0.
  - q2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= q2, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
- Glitch rule: any glitch shorter than DEBOUNCE_CYCLES sampled cycles is fully rejected, because the counter restarts on any equal sample.
- Legal stable vectors: 000, 001, 011, 111. Illegal: 010, 100, 101, 110.
- Output register, updated each edge from the current stable vector:
  - Legal and fault=0: s <= stable; s_valid <= 1; level_changed <= (stable != s); illegal counter <= 0.
  - Illegal and fault=0: s holds; s_valid <= 0; level_changed <= 0; illegal counter increments, saturating at FAULT_CYCLES. When it reaches FAULT_CYCLES, fault <= 1.
  - fault=1: s <= 000 (forces maximum fill, the safe state); s_valid <= 0. level_changed pulses once if s was not already 000.
- fault clears only on reset.
- Latency: a clean step on s_raw settling before edge E1 appears on s at edge E(3+DEBOUNCE_CYCLES), i.e. 7 edges for the default.
- First edge after reset release: stable=000 is legal, so s_valid goes 1, s stays 000, and level_changed stays 0.
- Multi-bit steps (e.g. 001->111) may pass through a transient illegal or intermediate vector because bits debounce independently. An illegal transient shorter than FAULT_CYCLES never raises fault; s holds the last legal value during it.
- Simultaneous events: with the illegal counter at FAULT_CYCLES-1, a returning legal vector wins and the counter clears, so no fault is raised.
- s_raw toggling every cycle indefinitely: stable never changes and s holds.

Test Plan:
1. Release reset, s_raw=000 -> first edge after release: s=000, s_valid=1, fault=0, level_changed=0.
2. Step s_raw 000->001, then hold -> s=001 exactly 7 edges later; level_changed high for exactly that one cycle.
3. s_raw=001 with bit 2 pulsed high for 3 cycles -> s stays 001; no level_changed pulse; s_valid remains 1.
4. Step s_raw 001->011->111, each held 12 cycles -> s steps 001->011->111, each 7 edges after the raw change, with one level_changed pulse per step.
5. From s=011, hold s_raw=101 (illegal) -> s_valid=0 while s holds 011. fault=1 at the 8th illegal cycle, and s=000 on the next edge. Then restoring s_raw=111 -> fault and s stay 1/000 until reset.
6. Drive s_raw=010 for 7 illegal cycles, then s_raw=011 -> no fault; s=011, s_valid=1. Then assert reset mid-debounce -> all outputs return to reset values immediately, asynchronously.

Source files
------------

// File: rtl/water_level_sensor_cond.sv
// Conditioning front end for the three float sensors: two-flop synchroniser,
// per-bit debounce, thermometer-code legality check and a sticky fault.
module water_level_sensor_cond #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3,
    parameter int FAULT_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:1] s_raw,
    output logic [3:1] s,
    output logic       s_valid,
    output logic       level_changed,
    output logic       fault
);

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       FAULT_LIMIT = 8'(FAULT_CYCLES);

    logic [3:1] q1;
    logic [3:1] q2;
    logic [3:1] stable;
    logic [7:0] ill_cnt;
    logic       legal;

    // Plain flop-to-flop path so the second stage can resolve metastability.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its source regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q1 <= '0;
            q2 <= '0;
        end else begin
            q1 <= s_raw;
            q2 <= q1;
        end
    end

    // Each bit debounces on its own; any matching sample restarts its count.
    for (genvar b = 1; b <= 3; b++) begin : g_debounce
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt       <= '0;
                stable[b] <= 1'b0;
            end else if (q2[b] == stable[b]) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                stable[b] <= q2[b];
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Only thermometer codes are physically consistent float positions.
    always_comb begin
        legal = 1'b0;
        case (stable)
            3'b000, 3'b001, 3'b011, 3'b111: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
    end

    // Once fault is set the bus is forced to 000 (maximum fill, the safe
    // state) and stays there until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s             <= '0;
            s_valid       <= 1'b0;
            level_changed <= 1'b0;
            fault         <= 1'b0;
            ill_cnt       <= '0;
        end else if (fault) begin
            s             <= '0;
            s_valid       <= 1'b0;
            level_changed <= (s != 3'b000);
        end else if (legal) begin
            s             <= stable;
            s_valid       <= 1'b1;
            level_changed <= (stable != s);
            ill_cnt       <= '0;
        end else begin
            s_valid       <= 1'b0;
            level_changed <= 1'b0;
            if (ill_cnt != FAULT_LIMIT) begin
                ill_cnt <= ill_cnt + 8'd1;
            end
            if (ill_cnt >= FAULT_LIMIT - 8'd1) begin
                fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_water_level_sensor_cond.sv
// Self-checking bench for water_level_sensor_cond: expected outputs are queued
// against a future edge number when stimulus is applied and compared then.
module tb_water_level_sensor_cond;

    logic       clk;
    logic       reset;
    logic [3:1] s_raw;
    logic [3:1] s;
    logic       s_valid;
    logic       level_changed;
    logic       fault;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt;

    typedef struct {
        string      tag;
        int         edge_no;
        logic [3:1] s;
        logic       v;
        logic       lc;
        logic       f;
    } exp_t;

    exp_t sb[$];

    water_level_sensor_cond dut (
        .clk           (clk),
        .reset         (reset),
        .s_raw         (s_raw),
        .s             (s),
        .s_valid       (s_valid),
        .level_changed (level_changed),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges counted since the last reset release; edge 1 is the first one.
    always @(posedge clk or negedge reset) begin
        if (!reset) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic expect_at(input string tag, input int k, input logic [3:1] es,
                             input logic ev, input logic elc, input logic ef);
        exp_t e;
        e.tag     = tag;
        e.edge_no = edge_cnt + k;
        e.s       = es;
        e.v       = ev;
        e.lc      = elc;
        e.f       = ef;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s"},  32'(s),             32'(3'b000));
        check({tag, "_v"},  32'(s_valid),       32'(1'b0));
        check({tag, "_lc"}, 32'(level_changed), 32'(1'b0));
        check({tag, "_f"},  32'(fault),         32'(1'b0));
    endtask

    task automatic drain();
        int b = 0;
        while (sb.size() != 0 && b < 50) begin
            tick(1);
            b++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    // A clean single-step change: old value on the 6th edge, new value with a
    // level_changed pulse on the 7th, pulse gone on the 8th.
    task automatic step(input string tag, input logic [3:1] raw,
                        input logic [3:1] old_s, input logic [3:1] new_s);
        s_raw = raw;
        expect_at({tag, "_pre"},  6, old_s, 1'b1, 1'b0, 1'b0);
        expect_at({tag, "_step"}, 7, new_s, 1'b1, 1'b1, 1'b0);
        expect_at({tag, "_post"}, 8, new_s, 1'b1, 1'b0, 1'b0);
        tick(12);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].edge_no == edge_cnt) begin
                    check({sb[i].tag, "_s"},  32'(s),             32'(sb[i].s));
                    check({sb[i].tag, "_v"},  32'(s_valid),       32'(sb[i].v));
                    check({sb[i].tag, "_lc"}, 32'(level_changed), 32'(sb[i].lc));
                    check({sb[i].tag, "_f"},  32'(fault),         32'(sb[i].f));
                    sb.delete(i);
                end else if (sb[i].edge_no < edge_cnt) begin
                    check({sb[i].tag, "_missed"}, 32'(edge_cnt), 32'(sb[i].edge_no));
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        s_raw = 3'b000;
        tick(3);
        check_reset_outputs("rst0");

        // 1: first edge after release
        reset = 1'b1;
        expect_at("t1_first", 1, 3'b000, 1'b1, 1'b0, 1'b0);
        expect_at("t1_hold",  3, 3'b000, 1'b1, 1'b0, 1'b0);
        tick(3);

        // 2: 000 -> 001 with 7-edge latency
        step("t2", 3'b001, 3'b000, 3'b001);

        // 3: 3-cycle glitch on bit 2 is rejected
        s_raw = 3'b011;
        for (int k = 1; k <= 10; k++) begin
            expect_at("t3_glitch", k, 3'b001, 1'b1, 1'b0, 1'b0);
        end
        tick(3);
        s_raw = 3'b001;
        tick(10);

        // 4: walk up the thermometer, then back to 011
        step("t4a", 3'b011, 3'b001, 3'b011);
        step("t4b", 3'b111, 3'b011, 3'b111);
        step("t4c", 3'b011, 3'b111, 3'b011);

        // 5: sustained illegal vector raises a sticky fault
        s_raw = 3'b101;
        expect_at("t5_pre",    6, 3'b011, 1'b1, 1'b0, 1'b0);
        expect_at("t5_ill1",   7, 3'b011, 1'b0, 1'b0, 1'b0);
        expect_at("t5_ill7",  13, 3'b011, 1'b0, 1'b0, 1'b0);
        expect_at("t5_ill8",  14, 3'b011, 1'b0, 1'b0, 1'b1);
        expect_at("t5_safe",  15, 3'b000, 1'b0, 1'b1, 1'b1);
        expect_at("t5_safe2", 16, 3'b000, 1'b0, 1'b0, 1'b1);
        tick(20);
        s_raw = 3'b111;
        expect_at("t5_stick1", 10, 3'b000, 1'b0, 1'b0, 1'b1);
        expect_at("t5_stick2", 25, 3'b000, 1'b0, 1'b0, 1'b1);
        tick(30);
        drain();

        reset = 1'b0;
        #1;
        check_reset_outputs("rst_fault");
        s_raw = 3'b011;
        tick(3);
        reset = 1'b1;
        expect_at("t6_first", 1, 3'b000, 1'b1, 1'b0, 1'b0);
        expect_at("t6_pre",   6, 3'b000, 1'b1, 1'b0, 1'b0);
        expect_at("t6_up",    7, 3'b011, 1'b1, 1'b1, 1'b0);
        expect_at("t6_post",  8, 3'b011, 1'b1, 1'b0, 1'b0);
        tick(12);

        // 6: illegal run one short of the fault limit, then legal again
        s_raw = 3'b010;
        expect_at("t6_pre_ill", 6, 3'b011, 1'b1, 1'b0, 1'b0);
        expect_at("t6_ill1",    7, 3'b011, 1'b0, 1'b0, 1'b0);
        expect_at("t6_ill7",   13, 3'b011, 1'b0, 1'b0, 1'b0);
        expect_at("t6_back",   14, 3'b011, 1'b1, 1'b0, 1'b0);
        expect_at("t6_nofault",20, 3'b011, 1'b1, 1'b0, 1'b0);
        tick(7);
        s_raw = 3'b011;
        tick(15);
        drain();

        // Reset in the middle of a debounce clears everything at once
        s_raw = 3'b001;
        tick(3);
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        s_raw = 3'b000;
        tick(2);
        reset = 1'b1;
        expect_at("t6_clean1", 1, 3'b000, 1'b1, 1'b0, 1'b0);
        expect_at("t6_clean8", 8, 3'b000, 1'b1, 1'b0, 1'b0);
        tick(10);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
